// File: rtl/motor_bridge_drv.sv
// H-bridge drive for one DC motor: 2-bit command -> IN1/IN2/PWM enable with dead-time and optional
// soft-start duty ramp (MOTOR_BRIDGE_SOFTSTART_EN). Outputs move 2 clk after cmd; no backpressure.
module motor_bridge_drv #(
    parameter int PWM_BITS  = 8,
    parameter int DUTY_MAX  = 200,
    parameter int RAMP_STEP = 4,
    parameter int RAMP_DIV  = 1000,
    parameter int DEAD_CYC  = 500
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [1:0]          cmd,
    output logic                in1,
    output logic                in2,
    output logic                ena,
    output logic                running,
    output logic [PWM_BITS:0]   duty_o
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_RUN   = 2'd1;
    localparam logic [1:0] S_DEAD  = 2'd2;
    localparam logic [1:0] S_BRAKE = 2'd3;

    localparam logic [1:0] C_COAST = 2'd0;
    localparam logic [1:0] C_FWD   = 2'd1;
    localparam logic [1:0] C_REV   = 2'd2;
    localparam logic [1:0] C_BRAKE = 2'd3;

    localparam int DW  = PWM_BITS + 1;
    localparam int DCW = $clog2(DEAD_CYC + 1);

    localparam logic [DW-1:0]  DUTY_MAX_V = DW'(DUTY_MAX);
    localparam logic [DCW-1:0] DEAD_LAST  = DCW'(DEAD_CYC - 1);

`ifdef MOTOR_BRIDGE_SOFTSTART_EN
    localparam logic [DW-1:0] RUN_ENTRY_DUTY = '0;
`else
    localparam logic [DW-1:0] RUN_ENTRY_DUTY = DUTY_MAX_V;
`endif

    logic [1:0]          cmd_q;
    logic [1:0]          state, state_n;
    logic [1:0]          dir, dir_n;
    logic [1:0]          target, target_n;
    logic [DCW-1:0]      dead_cnt, dead_cnt_n;
    logic [DW-1:0]       duty, duty_n, duty_ramped;
    logic [PWM_BITS-1:0] pwm_cnt, pwm_n;

    assign pwm_n = pwm_cnt + 1'b1;

`ifdef MOTOR_BRIDGE_SOFTSTART_EN
    localparam int RCW = $clog2(RAMP_DIV + 1);
    localparam logic [RCW-1:0] RAMP_LAST = RCW'(RAMP_DIV - 1);

    logic [RCW-1:0] ramp_cnt;
    logic [DW:0]    ramp_sum;
    logic           ramp_tick;

    assign ramp_tick = (ramp_cnt == RAMP_LAST);
    assign ramp_sum  = {1'b0, duty} + (DW+1)'(RAMP_STEP);

    // Saturate at DUTY_MAX so a step that does not divide evenly never overshoots.
    always_comb begin
        duty_ramped = duty;
        if (ramp_tick) begin
            if (ramp_sum > (DW+1)'(DUTY_MAX)) duty_ramped = DUTY_MAX_V;
            else                              duty_ramped = ramp_sum[DW-1:0];
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)                                  ramp_cnt <= '0;
        else if (state_n != S_RUN || state != S_RUN) ramp_cnt <= '0;
        else if (ramp_tick)                        ramp_cnt <= '0;
        else                                       ramp_cnt <= ramp_cnt + 1'b1;
    end
`else
    assign duty_ramped = duty;
`endif

    always_comb begin
        state_n    = state;
        dir_n      = dir;
        target_n   = target;
        dead_cnt_n = dead_cnt;
        duty_n     = '0;
        case (state)
            S_IDLE: begin
                if (cmd_q == C_FWD || cmd_q == C_REV) begin
                    state_n = S_RUN;
                    dir_n   = cmd_q;
                    duty_n  = RUN_ENTRY_DUTY;
                end else if (cmd_q == C_BRAKE) begin
                    state_n = S_BRAKE;
                end
            end
            S_RUN: begin
                if (cmd_q == dir) begin
                    duty_n = duty_ramped;
                end else if (cmd_q == C_COAST) begin
                    state_n = S_IDLE;
                end else if (cmd_q == C_BRAKE) begin
                    state_n = S_BRAKE;
                end else begin
                    state_n    = S_DEAD;
                    target_n   = cmd_q;
                    dead_cnt_n = '0;
                end
            end
            S_DEAD: begin
                if (cmd_q == C_COAST) begin
                    state_n = S_IDLE;
                end else if (cmd_q == C_BRAKE) begin
                    state_n = S_BRAKE;
                end else if (cmd_q != target) begin
                    // Direction changed again mid dead-time: the full gap starts over.
                    target_n   = cmd_q;
                    dead_cnt_n = '0;
                end else if (dead_cnt == DEAD_LAST) begin
                    state_n = S_RUN;
                    dir_n   = target;
                    duty_n  = RUN_ENTRY_DUTY;
                end else begin
                    dead_cnt_n = dead_cnt + 1'b1;
                end
            end
            default: begin
                if (cmd_q == C_COAST) begin
                    state_n = S_IDLE;
                end else if (cmd_q == C_FWD || cmd_q == C_REV) begin
                    state_n    = S_DEAD;
                    target_n   = cmd_q;
                    dead_cnt_n = '0;
                end
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cmd_q    <= C_COAST;
            state    <= S_IDLE;
            dir      <= 2'd0;
            target   <= 2'd0;
            dead_cnt <= '0;
            duty     <= '0;
            pwm_cnt  <= '0;
            in1      <= 1'b0;
            in2      <= 1'b0;
            ena      <= 1'b0;
        end else begin
            cmd_q    <= cmd;
            state    <= state_n;
            dir      <= dir_n;
            target   <= target_n;
            dead_cnt <= dead_cnt_n;
            duty     <= duty_n;
            pwm_cnt  <= pwm_n;
            // Pins are decoded from next-cycle state so they line up with state/duty/pwm_cnt.
            in1      <= (state_n == S_RUN && dir_n == C_FWD) || (state_n == S_BRAKE);
            in2      <= (state_n == S_RUN && dir_n == C_REV) || (state_n == S_BRAKE);
            ena      <= (state_n == S_RUN) ? ({1'b0, pwm_n} < duty_n) : (state_n == S_BRAKE);
        end
    end

    assign running = (state == S_RUN);
    assign duty_o  = duty;

endmodule
